sensor_timing_engine: RTL and testbench
=======================================

SENSOR_TIMING_ENGINE -- requirements
Module: sensor_timing_engine

Interface
REQ-001 Parameter NUM_CH, default 10, is the number of sensor channels; legal range 1..16.
REQ-002 Parameter TIME_W, default 16, is the width of per-channel acquisition time and timeout.
REQ-003 Parameter TICK_W, default 32, is the width of the ISR-to-ISR tick counter.
REQ-004 clk  in  1  single clock; reset is asynchronous and active-low on rst_n.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 event_qualifier  in  1  qualified PWM carrier peak/valley pulse.
REQ-007 user_ratio  in  16  number of qualified events between auto triggers.
REQ-008 do_auto_triggering / send_manual_trigger  in  1/1  trigger mode select; manual request pulse.
REQ-009 en_bits / done  in  NUM_CH/NUM_CH  per-channel enable; per-channel done level.
REQ-010 timeout_cycles  in  TIME_W  acquisition timeout in clk cycles; 0 disables the timeout.
REQ-011 sched_source_mode / reset_sched_isr / clear_stats  in  1/1/1  ISR source; ISR clear; statistics clear.
REQ-012 trigger / sched_isr  out  1/1  sensor start pulse; scheduler interrupt level.
REQ-013 ch_time / ch_time_max  out  NUM_CH*TIME_W each  last and maximum done-edge time per channel, channel i at [i*TIME_W +: TIME_W].
REQ-014 timeout_flags / overrun_cnt / sched_tick_time  out  NUM_CH/16/TICK_W  sticky timeouts; missed-trigger count; last ISR period.

Function
REQ-015 Ratio counter shall clear when it equals user_ratio and otherwise increment on event_qualifier; ratio_hit = (count == user_ratio), so user_ratio=0 gives ratio_hit every cycle.
REQ-016 all_done = at least one channel enabled AND every enabled channel has done high or its timeout flag set during the current acquisition.
REQ-017 State machine IDLE -> ACQ on trigger; ACQ -> IDLE when all_done; ACQ -> IDLE on timeout; with no channel enabled the FSM shall remain in IDLE.
REQ-018 trigger shall be a one-cycle pulse registered from: (do_auto_triggering & ratio_hit & state==IDLE & sensors enabled) OR (manual queued & event_qualifier & state==IDLE & sensors enabled).
REQ-019 A manual request shall stay queued until trigger fires; a request arriving on the same cycle as trigger shall remain queued.
REQ-020 When auto mode has ratio_hit while state==ACQ, overrun_cnt shall increment, saturating at 0xFFFF.
REQ-021 Acquisition timer shall clear on trigger, increment in ACQ, and saturate at all-ones of TIME_W.
REQ-022 On a rising edge of done[i] in ACQ, ch_time[i] shall capture the timer value; ch_time_max[i] shall update when the captured value exceeds it; done edges in IDLE shall be ignored.
REQ-023 In ACQ with timeout_cycles != 0, when the timer equals timeout_cycles, every enabled channel whose done is low shall set its timeout_flags bit and the FSM shall return to IDLE.
REQ-024 clear_stats shall zero ch_time_max, timeout_flags and overrun_cnt the following cycle; clear_stats takes priority over a same-cycle update.
REQ-025 sched_isr shall set on ratio_hit when sched_source_mode=0 or no channel is enabled, and set on the ACQ->IDLE transition when sched_source_mode=1; otherwise it shall clear on reset_sched_isr, and set wins a simultaneous clear.
REQ-026 Tick counter shall reset on the sched_isr rising edge and load its prior value into sched_tick_time; it shall wrap at TICK_W.
REQ-027 en_bits changes during ACQ shall take effect immediately in all_done evaluation.

Reset
REQ-028 Asserting rst_n low shall force state IDLE, and all counters, flags, queued requests and outputs to 0, including mid-acquisition.
REQ-029 Done-edge and ISR-edge history registers shall also reset to 0, so that a done held high through reset does not capture a time.

Structure
REQ-030 Package sensor_timing_pkg shall hold the FSM state enum (IDLE, ACQ) and the default parameter constants.
REQ-031 Per-channel edge detection, time capture, maximum tracking and timeout flagging shall be one sub-module, timing_channel, instantiated NUM_CH times.

Verification
REQ-032 Auto trigger: NUM_CH=10, en_bits=0x001, user_ratio=3, done[0] rises 40 cycles after trigger -> trigger on the 3rd qualifier, ch_time[0]=40, sched_isr (mode 1) on done.
REQ-033 Timeout: en_bits=0x003, timeout_cycles=100, only done[0] rises -> timeout_flags=0x002 at cycle 100, FSM returns to IDLE, ISR asserted.
REQ-034 Overrun: user_ratio=0, done never rises, timeout disabled -> overrun_cnt increments every cycle and saturates at 0xFFFF.
REQ-035 Manual trigger: request during ACQ -> trigger on the first qualifier after all_done, and exactly one trigger is issued.
REQ-036 Statistics: captures of 50 then 30 -> ch_time_max=50; clear_stats -> ch_time_max=0.
REQ-037 Reset during ACQ with done high -> all outputs 0, and no capture after reset release.

Source files
------------

// File: rtl/sensor_timing_pkg.sv
// Shared types and default sizing for the sensor timing engine.
package sensor_timing_pkg;

  localparam int DEF_NUM_CH = 10;
  localparam int DEF_TIME_W = 16;
  localparam int DEF_TICK_W = 32;
  localparam int RATIO_W    = 16;
  localparam int OVR_W      = 16;

  typedef enum logic {
    IDLE = 1'b0,
    ACQ  = 1'b1
  } state_t;

endpackage

// File: rtl/timing_channel.sv
// One sensor channel: done-edge capture, maximum tracking and sticky timeout flag.
module timing_channel #(
  parameter int TIME_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              done,
  input  logic              acq,
  input  logic [TIME_W-1:0] timer,
  input  logic              timeout_hit,
  input  logic              clear_stats,
  output logic [TIME_W-1:0] ch_time,
  output logic [TIME_W-1:0] ch_time_max,
  output logic              timeout_flag
);

  logic done_d;
  logic cap;

  assign cap = acq && done && !done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_d  <= 1'b0;
      ch_time <= '0;
    end else begin
      done_d <= done;
      if (cap) ch_time <= timer;
    end
  end

  // clear_stats wins over a capture or timeout landing on the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_time_max  <= '0;
      timeout_flag <= 1'b0;
    end else if (clear_stats) begin
      ch_time_max  <= '0;
      timeout_flag <= 1'b0;
    end else begin
      if (cap && (timer > ch_time_max)) ch_time_max <= timer;
      if (timeout_hit && en && !done) timeout_flag <= 1'b1;
    end
  end

endmodule

// File: rtl/sensor_timing_engine.sv
// Sensor acquisition sequencer: PWM-synchronous triggering, per-channel timing, scheduler ISR.
//   state | meaning
//   IDLE  | waiting for an auto or manual trigger
//   ACQ   | sensors converting; timer running until all done or timeout
module sensor_timing_engine
  import sensor_timing_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int TIME_W = DEF_TIME_W,
  parameter int TICK_W = DEF_TICK_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     event_qualifier,
  input  logic [15:0]              user_ratio,
  input  logic                     do_auto_triggering,
  input  logic                     send_manual_trigger,
  input  logic [NUM_CH-1:0]        en_bits,
  input  logic [NUM_CH-1:0]        done,
  input  logic [TIME_W-1:0]        timeout_cycles,
  input  logic                     sched_source_mode,
  input  logic                     reset_sched_isr,
  input  logic                     clear_stats,
  output logic                     trigger,
  output logic                     sched_isr,
  output logic [NUM_CH*TIME_W-1:0] ch_time,
  output logic [NUM_CH*TIME_W-1:0] ch_time_max,
  output logic [NUM_CH-1:0]        timeout_flags,
  output logic [15:0]              overrun_cnt,
  output logic [TICK_W-1:0]        sched_tick_time
);

  state_t             state, state_nxt;
  logic [RATIO_W-1:0] ratio_cnt;
  logic               ratio_hit;
  logic               man_q;
  logic               any_en;
  logic               in_acq;
  logic               timeout_hit;
  logic               all_done;
  logic               trig_nxt;
  logic               acq_end;
  logic               isr_set;
  logic               isr_d;
  logic [TIME_W-1:0]  timer;
  logic [TICK_W-1:0]  tick_cnt;

  assign ratio_hit   = (ratio_cnt == user_ratio);
  assign any_en      = |en_bits;
  assign in_acq      = (state == ACQ);
  assign timeout_hit = in_acq && (timeout_cycles != '0) && (timer == timeout_cycles);
  assign all_done    = any_en && (&(~en_bits | done | {NUM_CH{timeout_hit}}));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // ~trigger keeps the start pulse to a single cycle while ratio_hit is held
  always_comb begin
    state_nxt = state;
    trig_nxt  = 1'b0;
    acq_end   = 1'b0;
    isr_set   = 1'b0;
    case (state)
      IDLE: if (trigger && any_en) state_nxt = ACQ;
      ACQ:  if (all_done || timeout_hit) state_nxt = IDLE;
    endcase
    trig_nxt = !trigger && (state == IDLE) && any_en &&
               ((do_auto_triggering && ratio_hit) || (man_q && event_qualifier));
    acq_end  = in_acq && (state_nxt == IDLE);
    isr_set  = (ratio_hit && (!sched_source_mode || !any_en)) ||
               (sched_source_mode && acq_end);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ratio_cnt <= '0;
      trigger   <= 1'b0;
      man_q     <= 1'b0;
    end else begin
      if (ratio_hit)            ratio_cnt <= '0;
      else if (event_qualifier) ratio_cnt <= ratio_cnt + RATIO_W'(1);
      trigger <= trig_nxt;
      if (send_manual_trigger) man_q <= 1'b1;
      else if (trigger)        man_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer       <= '0;
      overrun_cnt <= '0;
    end else begin
      if (trigger)                   timer <= '0;
      else if (in_acq && timer != '1) timer <= timer + TIME_W'(1);
      if (clear_stats)
        overrun_cnt <= '0;
      else if (do_auto_triggering && ratio_hit && in_acq && overrun_cnt != '1)
        overrun_cnt <= overrun_cnt + OVR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sched_isr       <= 1'b0;
      isr_d           <= 1'b0;
      tick_cnt        <= '0;
      sched_tick_time <= '0;
    end else begin
      if (isr_set)              sched_isr <= 1'b1;
      else if (reset_sched_isr) sched_isr <= 1'b0;
      isr_d <= sched_isr;
      if (sched_isr && !isr_d) begin
        sched_tick_time <= tick_cnt;
        tick_cnt        <= '0;
      end else begin
        tick_cnt <= tick_cnt + TICK_W'(1);
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    timing_channel #(.TIME_W(TIME_W)) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en_bits[i]),
      .done         (done[i]),
      .acq          (in_acq),
      .timer        (timer),
      .timeout_hit  (timeout_hit),
      .clear_stats  (clear_stats),
      .ch_time      (ch_time[i*TIME_W +: TIME_W]),
      .ch_time_max  (ch_time_max[i*TIME_W +: TIME_W]),
      .timeout_flag (timeout_flags[i])
    );
  end

endmodule

// File: tb/tb_sensor_timing_engine.sv
// Directed bench for sensor_timing_engine: inputs driven 1 ns after posedge, outputs sampled at negedge.
module tb_sensor_timing_engine;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         event_qualifier;
  logic [15:0]  user_ratio;
  logic         do_auto_triggering;
  logic         send_manual_trigger;
  logic [9:0]   en_bits;
  logic [9:0]   done;
  logic [15:0]  timeout_cycles;
  logic         sched_source_mode;
  logic         reset_sched_isr;
  logic         clear_stats;
  logic         trigger;
  logic         sched_isr;
  logic [159:0] ch_time;
  logic [159:0] ch_time_max;
  logic [9:0]   timeout_flags;
  logic [15:0]  overrun_cnt;
  logic [31:0]  sched_tick_time;

  int checks = 0;
  int errors = 0;
  int trig_count = 0;

  sensor_timing_engine #(.NUM_CH(10), .TIME_W(16), .TICK_W(32)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .event_qualifier     (event_qualifier),
    .user_ratio          (user_ratio),
    .do_auto_triggering  (do_auto_triggering),
    .send_manual_trigger (send_manual_trigger),
    .en_bits             (en_bits),
    .done                (done),
    .timeout_cycles      (timeout_cycles),
    .sched_source_mode   (sched_source_mode),
    .reset_sched_isr     (reset_sched_isr),
    .clear_stats         (clear_stats),
    .trigger             (trigger),
    .sched_isr           (sched_isr),
    .ch_time             (ch_time),
    .ch_time_max         (ch_time_max),
    .timeout_flags       (timeout_flags),
    .overrun_cnt         (overrun_cnt),
    .sched_tick_time     (sched_tick_time)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (trigger === 1'b1) trig_count <= trig_count + 1;

  function automatic logic [15:0] cht(input int i);
    return ch_time[i*16 +: 16];
  endfunction

  function automatic logic [15:0] chm(input int i);
    return ch_time_max[i*16 +: 16];
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_defaults();
    event_qualifier     = 1'b0;
    user_ratio          = 16'hFFFF;
    do_auto_triggering  = 1'b0;
    send_manual_trigger = 1'b0;
    en_bits             = '0;
    done                = '0;
    timeout_cycles      = '0;
    sched_source_mode   = 1'b1;
    reset_sched_isr     = 1'b0;
    clear_stats         = 1'b0;
  endtask

  task automatic do_reset();
    apply_defaults();
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic pulse_qual();
    event_qualifier = 1'b1;
    tick(1);
    event_qualifier = 1'b0;
  endtask

  // Three qualifiers with user_ratio=3: trigger is high two cycles after the third.
  task automatic fire3();
    tick(1);
    pulse_qual(); tick(2);
    pulse_qual(); tick(2);
    pulse_qual();
  endtask

  task automatic wait_trig(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (trigger === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    apply_defaults();
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({trigger, sched_isr, timeout_flags, overrun_cnt} !== 28'h0) begin
      errors++; $display("FAIL reset_ctrl got %h want 0", {trigger, sched_isr, timeout_flags, overrun_cnt});
    end
    checks++;
    if ({ch_time, ch_time_max} !== 320'h0) begin
      errors++; $display("FAIL reset_times got %h want 0", {ch_time, ch_time_max});
    end
    tick(1);
    rst_n = 1'b1;
    tick(3);
    @(negedge clk);
    checks++;
    if ({trigger, sched_isr, sched_tick_time, overrun_cnt} !== 50'h0) begin
      errors++; $display("FAIL reset_release got %h want 0", {trigger, sched_isr, sched_tick_time, overrun_cnt});
    end
  endtask

  task automatic test_auto_trigger();
    int base;
    bit ok;
    do_reset();
    en_bits = 10'h001; user_ratio = 16'd3; do_auto_triggering = 1'b1;
    base = trig_count;
    pulse_qual(); tick(2);
    pulse_qual(); tick(4);
    checks++;
    if (trig_count - base != 0) begin
      errors++; $display("FAIL auto_two_quals triggers got %0d want 0", trig_count - base);
    end
    pulse_qual();
    wait_trig(ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL auto_third_qual trigger got 0 want 1");
    end
    // ACQ starts the cycle after trigger with timer 0, so 41 edges later timer reads 40
    repeat (41) @(posedge clk);
    #1 done = 10'h001;
    @(negedge clk);
    checks++;
    if (sched_isr !== 1'b0) begin
      errors++; $display("FAIL auto_isr_early got %b want 0", sched_isr);
    end
    @(negedge clk);
    checks++;
    if (cht(0) !== 16'd40) begin
      errors++; $display("FAIL auto_ch_time got %0d want 40", cht(0));
    end
    checks++;
    if (sched_isr !== 1'b1) begin
      errors++; $display("FAIL auto_isr_on_done got %b want 1", sched_isr);
    end
    tick(2);
    checks++;
    if (trig_count - base != 1 || overrun_cnt !== 16'd0) begin
      errors++; $display("FAIL auto_single got trig %0d ovr %0d want 1 0", trig_count - base, overrun_cnt);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    do_reset();
    en_bits = 10'h003; user_ratio = 16'd3; do_auto_triggering = 1'b1; timeout_cycles = 16'd100;
    fire3();
    wait_trig(ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL to_trigger got 0 want 1");
    end
    repeat (21) @(posedge clk);
    #1 done = 10'h001;
    repeat (80) @(posedge clk);
    @(negedge clk);
    checks++;
    if (timeout_flags !== 10'h000 || sched_isr !== 1'b0) begin
      errors++; $display("FAIL to_early got flags %h isr %b want 000 0", timeout_flags, sched_isr);
    end
    @(negedge clk);
    checks++;
    if (timeout_flags !== 10'h002) begin
      errors++; $display("FAIL to_flags got %h want 002", timeout_flags);
    end
    checks++;
    if (sched_isr !== 1'b1) begin
      errors++; $display("FAIL to_isr got %b want 1", sched_isr);
    end
    checks++;
    if (cht(0) !== 16'd20 || cht(1) !== 16'd0) begin
      errors++; $display("FAIL to_ch_time got %0d %0d want 20 0", cht(0), cht(1));
    end
    fire3();
    wait_trig(ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL to_back_to_idle retrigger got 0 want 1");
    end
  endtask

  task automatic test_overrun();
    do_reset();
    en_bits = 10'h001; do_auto_triggering = 1'b1;
    user_ratio = 16'd0;
    repeat (3) @(negedge clk);
    checks++;
    if (overrun_cnt !== 16'd0) begin
      errors++; $display("FAIL ovr_start got %0d want 0", overrun_cnt);
    end
    @(negedge clk);
    checks++;
    if (overrun_cnt !== 16'd1) begin
      errors++; $display("FAIL ovr_first got %0d want 1", overrun_cnt);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (overrun_cnt !== 16'd11) begin
      errors++; $display("FAIL ovr_count got %0d want 11", overrun_cnt);
    end
    repeat (65540) @(negedge clk);
    checks++;
    if (overrun_cnt !== 16'hFFFF) begin
      errors++; $display("FAIL ovr_sat got %h want ffff", overrun_cnt);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (overrun_cnt !== 16'hFFFF || sched_isr !== 1'b0) begin
      errors++; $display("FAIL ovr_hold got %h isr %b want ffff 0", overrun_cnt, sched_isr);
    end
    tick(1);
    clear_stats = 1'b1;
    tick(1);
    clear_stats = 1'b0;
    @(negedge clk);
    checks++;
    if (overrun_cnt !== 16'd0) begin
      errors++; $display("FAIL ovr_clear_prio got %0d want 0", overrun_cnt);
    end
    @(negedge clk);
    checks++;
    if (overrun_cnt !== 16'd1) begin
      errors++; $display("FAIL ovr_after_clear got %0d want 1", overrun_cnt);
    end
  endtask

  task automatic test_manual();
    int base;
    do_reset();
    en_bits = 10'h001;
    base = trig_count;
    pulse_qual(); tick(3);
    checks++;
    if (trig_count - base != 0) begin
      errors++; $display("FAIL man_no_request got %0d want 0", trig_count - base);
    end
    send_manual_trigger = 1'b1; tick(1); send_manual_trigger = 1'b0;
    tick(2);
    pulse_qual(); tick(4);
    checks++;
    if (trig_count - base != 1) begin
      errors++; $display("FAIL man_first got %0d want 1", trig_count - base);
    end
    send_manual_trigger = 1'b1; tick(1); send_manual_trigger = 1'b0;
    pulse_qual(); tick(2); pulse_qual(); tick(2);
    checks++;
    if (trig_count - base != 1) begin
      errors++; $display("FAIL man_queued_in_acq got %0d want 1", trig_count - base);
    end
    done = 10'h001;
    tick(4);
    checks++;
    if (trig_count - base != 1) begin
      errors++; $display("FAIL man_wait_qual got %0d want 1", trig_count - base);
    end
    pulse_qual(); tick(5);
    pulse_qual(); tick(2); pulse_qual(); tick(5);
    checks++;
    if (trig_count - base != 2) begin
      errors++; $display("FAIL man_exactly_one got %0d want 2", trig_count - base);
    end
    // request held through the trigger cycle stays queued for the next qualifier
    send_manual_trigger = 1'b1; event_qualifier = 1'b1;
    tick(2);
    event_qualifier = 1'b0;
    tick(1);
    send_manual_trigger = 1'b0;
    tick(3);
    pulse_qual(); tick(5);
    checks++;
    if (trig_count - base != 4) begin
      errors++; $display("FAIL man_same_cycle_requeue got %0d want 4", trig_count - base);
    end
  endtask

  task automatic test_stats();
    bit ok;
    do_reset();
    en_bits = 10'h001; user_ratio = 16'd3; do_auto_triggering = 1'b1;
    fire3();
    wait_trig(ok);
    repeat (51) @(posedge clk);
    #1 done = 10'h001;
    tick(2);
    done = 10'h000;
    checks++;
    if (!ok || cht(0) !== 16'd50 || chm(0) !== 16'd50) begin
      errors++; $display("FAIL stats_first got trig %b time %0d max %0d want 1 50 50", ok, cht(0), chm(0));
    end
    fire3();
    wait_trig(ok);
    repeat (31) @(posedge clk);
    #1 done = 10'h001;
    tick(2);
    done = 10'h000;
    checks++;
    if (!ok || cht(0) !== 16'd30 || chm(0) !== 16'd50) begin
      errors++; $display("FAIL stats_second got trig %b time %0d max %0d want 1 30 50", ok, cht(0), chm(0));
    end
    clear_stats = 1'b1;
    tick(1);
    clear_stats = 1'b0;
    @(negedge clk);
    checks++;
    if (chm(0) !== 16'd0 || cht(0) !== 16'd30) begin
      errors++; $display("FAIL stats_clear got max %0d time %0d want 0 30", chm(0), cht(0));
    end
  endtask

  task automatic test_tick();
    int base;
    do_reset();
    sched_source_mode = 1'b0; user_ratio = 16'd4; reset_sched_isr = 1'b1;
    base = trig_count;
    event_qualifier = 1'b1;
    tick(30);
    // counter is zeroed on each ISR edge, so a 5-cycle period reads back as 4
    checks++;
    if (sched_tick_time !== 32'd4) begin
      errors++; $display("FAIL tick_period got %0d want 4", sched_tick_time);
    end
    checks++;
    if (trig_count - base != 0) begin
      errors++; $display("FAIL tick_no_channel_trigger got %0d want 0", trig_count - base);
    end
    event_qualifier = 1'b0;
  endtask

  task automatic test_reset_in_acq();
    int base;
    bit ok;
    do_reset();
    en_bits = 10'h003; user_ratio = 16'd3; do_auto_triggering = 1'b1;
    fire3();
    wait_trig(ok);
    repeat (11) @(posedge clk);
    #1 done = 10'h001;
    tick(3);
    checks++;
    if (!ok || cht(0) !== 16'd10) begin
      errors++; $display("FAIL rst_pre_capture got trig %b time %0d want 1 10", ok, cht(0));
    end
    rst_n = 1'b0;
    user_ratio = 16'd0;
    @(negedge clk);
    checks++;
    if ({trigger, sched_isr, ch_time, ch_time_max, timeout_flags, overrun_cnt, sched_tick_time} !== '0) begin
      errors++; $display("FAIL rst_mid_acq got %h want 0", {trigger, sched_isr, ch_time, ch_time_max, timeout_flags, overrun_cnt, sched_tick_time});
    end
    tick(1);
    base = trig_count;
    rst_n = 1'b1;
    tick(20);
    checks++;
    if (ch_time !== 160'h0 || ch_time_max !== 160'h0) begin
      errors++; $display("FAIL rst_no_capture got %h %h want 0", ch_time, ch_time_max);
    end
    checks++;
    if (trig_count - base != 1) begin
      errors++; $display("FAIL rst_retrigger got %0d want 1", trig_count - base);
    end
  endtask

  initial begin
    apply_defaults();
    rst_n = 1'b0;
    test_reset();
    test_auto_trigger();
    test_timeout();
    test_manual();
    test_stats();
    test_tick();
    test_reset_in_acq();
    test_overrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
